stopwatch_uart_reporter: RTL
============================

Name: stopwatch_uart_reporter

Overview:
- Reads the stopwatch time outputs (msec/sec/min/hour) and sends them as an ASCII frame "HH:MM:SS.cc\r\n" through the existing byte-level UART transmitter.
- The stopwatch produces time values; this block consumes them and feeds the TX byte interface.
- Sits between stopwatch outputs and uart_tx in the top level. A report is triggered by a request pulse, e.g. a decoded RX command or a debounced button.

Parameters:
- SEND_CRLF, 1, 1 = frame is 13 bytes (with CR LF); 0 = frame is 11 bytes (no terminator).
- CLAMP_VAL, 99, any field value above this is displayed as this value.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- i_report  input  1  one-cycle report request.
- msec  input  7  centiseconds, 0-99.
- sec  input  6  seconds, 0-59.
- min  input  6  minutes, 0-59.
- hour  input  5  hours, 0-23.
- i_tx_busy  input  1  uart_tx busy. It rises the cycle after o_tx_start is sampled and falls after the stop bit.
- o_tx_data  output  8  byte to transmit.
- o_tx_start  output  1  one-cycle start pulse to uart_tx.
- o_busy  output  1  high while a frame is in progress.

Behaviour:
- Reset values: o_tx_data=8'h00, o_tx_start=0, o_busy=0, pending=0, FSM=IDLE, byte index=0, snapshot registers=0.
- Reset is asynchronous and dominates everything. Reset mid-frame aborts the frame immediately; no further bytes are sent.
- Snapshot: at trigger acceptance, all four time fields are captured together in one cycle. This prevents a torn frame (e.g. sec rolling over while min is being sent).
- Conversion: each field is clamped to CLAMP_VAL, then split into tens = v/10 and ones = v%10. Each digit is sent as ASCII 8'h30 + digit. Every field is always two digits with a leading zero (hour 5 is sent as "05").
- Byte order, index 0-12: H1 H0 ':' M1 M0 ':' S1 S0 '.' C1 C0 CR(8'h0D) LF(8'h0A). With SEND_CRLF=0 the last index is 10.
- FSM states and transitions:
  - IDLE: on i_report or pending, capture the snapshot, clear pending, set index=0, go to LOAD.
  - LOAD: drive o_tx_data with the byte for the current index; go to START.
  - START: o_tx_start=1 for exactly this cycle; o_tx_data stays stable; go to WAIT_HI.
  - WAIT_HI: wait for i_tx_busy=1, then go to WAIT_LO.
  - WAIT_LO: wait for i_tx_busy=0. If index is the last byte, go to IDLE; otherwise increment index and go to LOAD.
- o_tx_data holds its value from LOAD until the next LOAD.
- o_busy=1 in every state except IDLE.
- Request while o_busy=1: sets pending (one deep). Further requests merge into it. The pending frame starts from IDLE on the cycle after the current frame ends, and takes a fresh snapshot at that point.
- Request in the same cycle IDLE is being exited by pending: merges into that frame; pending ends up cleared.
- i_tx_busy already high when entering START: not supported; uart_tx guarantees busy is low between bytes.
- Frame latency: trigger to first o_tx_start = 3 cycles (IDLE→LOAD→START).

Decomposition:
- Shared package stopwatch_pkg:
  - state enum (IDLE, LOAD, START, WAIT_HI, WAIT_LO);
  - ASCII constants: ASCII_0, ASCII_COLON, ASCII_DOT, ASCII_CR, ASCII_LF;
  - FRAME_LEN_CRLF=13, FRAME_LEN_NOCRLF=11.
- One sub-module: bin2ascii2, a combinational converter from 7-bit value (clamped) to two ASCII bytes {tens, ones}. It is instantiated four times.

Test Plan:
- Reset, then time 12:34:56.78 and one i_report pulse; uart_tx model returns busy 1 cycle after start, for 10 cycles → byte stream "12:34:56.78\r\n" (0x31 0x32 0x3A 0x33 0x34 0x3A 0x35 0x36 0x2E 0x37 0x38 0x0D 0x0A); exactly 13 start pulses; o_busy returns to 0.
- Time 00:00:05.09 → "00:00:05.09\r\n"; verifies leading zeros.
- Snapshot: request at 00:00:59.99, then advance inputs to 00:01:00.00 during byte 2 → frame is still "00:00:59.99".
- Three i_report pulses while busy → exactly one extra frame after the first; that frame holds the values present at its start; 26 bytes total.
- Assert rst=0 during byte 5 → o_tx_start=0 and o_busy=0 immediately; after release, no bytes are sent until a new request.
- SEND_CRLF=0 with msec=120 (out of range) → 11 bytes; centisecond field is "99".

Source files
------------

// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
// stopwatch_pkg : shared types and ASCII constants for the stopwatch reporter
// Revision      : 1.0
// ============================================================================
package stopwatch_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        START   = 3'd2,
        WAIT_HI = 3'd3,
        WAIT_LO = 3'd4
    } state_e;

    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_DOT   = 8'h2E;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    localparam int FRAME_LEN_CRLF   = 13;
    localparam int FRAME_LEN_NOCRLF = 11;

endpackage
`default_nettype wire

// File: rtl/bin2ascii2.sv
`default_nettype none
// ============================================================================
// bin2ascii2 : clamps a value and renders it as two ASCII decimal digits
// Revision   : 1.0
// ============================================================================
module bin2ascii2
    import stopwatch_pkg::*;
#(
    parameter int CLAMP_VAL = 99
) (
    input  logic [6:0] val_i,
    output logic [7:0] tens_o,
    output logic [7:0] ones_o
);

    logic [6:0] w_val;
    logic [6:0] w_tens;
    logic [6:0] w_ones;

    always_comb begin
        w_val = val_i;
        if (int'(val_i) > CLAMP_VAL) begin
            w_val = 7'(CLAMP_VAL);
        end
        w_tens = w_val / 7'd10;
        w_ones = w_val % 7'd10;
    end

    assign tens_o = ASCII_0 + {1'b0, w_tens};
    assign ones_o = ASCII_0 + {1'b0, w_ones};

endmodule
`default_nettype wire

// File: rtl/stopwatch_uart_reporter.sv
`default_nettype none
// ============================================================================
// stopwatch_uart_reporter : sends a snapshot "HH:MM:SS.cc\r\n" through uart_tx
// Revision                : 1.0
// ============================================================================
module stopwatch_uart_reporter
    import stopwatch_pkg::*;
#(
    parameter bit SEND_CRLF = 1'b1,
    parameter int CLAMP_VAL = 99
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_report,
    input  logic [6:0] msec,
    input  logic [5:0] sec,
    input  logic [5:0] min,
    input  logic [4:0] hour,
    input  logic       i_tx_busy,
    output logic [7:0] o_tx_data,
    output logic       o_tx_start,
    output logic       o_busy
);

    localparam logic [3:0] LAST_IDX = SEND_CRLF ? 4'd12 : 4'd10;

    state_e     state_q, state_d;
    logic [3:0] idx_q, idx_d;
    logic       pending_q, pending_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic [6:0] msec_q;
    logic [5:0] sec_q;
    logic [5:0] min_q;
    logic [4:0] hour_q;
    logic       w_capture;
    logic [7:0] w_byte;
    logic [7:0] w_h1, w_h0, w_m1, w_m0, w_s1, w_s0, w_c1, w_c0;

    bin2ascii2 #(.CLAMP_VAL(CLAMP_VAL)) u_hour (.val_i({2'b00, hour_q}), .tens_o(w_h1), .ones_o(w_h0));
    bin2ascii2 #(.CLAMP_VAL(CLAMP_VAL)) u_min  (.val_i({1'b0, min_q}),   .tens_o(w_m1), .ones_o(w_m0));
    bin2ascii2 #(.CLAMP_VAL(CLAMP_VAL)) u_sec  (.val_i({1'b0, sec_q}),   .tens_o(w_s1), .ones_o(w_s0));
    bin2ascii2 #(.CLAMP_VAL(CLAMP_VAL)) u_msec (.val_i(msec_q),          .tens_o(w_c1), .ones_o(w_c0));

    always_comb begin
        case (idx_q)
            4'd0:    w_byte = w_h1;
            4'd1:    w_byte = w_h0;
            4'd2:    w_byte = ASCII_COLON;
            4'd3:    w_byte = w_m1;
            4'd4:    w_byte = w_m0;
            4'd5:    w_byte = ASCII_COLON;
            4'd6:    w_byte = w_s1;
            4'd7:    w_byte = w_s0;
            4'd8:    w_byte = ASCII_DOT;
            4'd9:    w_byte = w_c1;
            4'd10:   w_byte = w_c0;
            4'd11:   w_byte = ASCII_CR;
            4'd12:   w_byte = ASCII_LF;
            default: w_byte = 8'h00;
        endcase
    end

    assign w_capture = (state_q == IDLE) && (i_report || pending_q);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pending_d = pending_q;
        tx_data_d = tx_data_q;
        case (state_q)
            IDLE: begin
                if (w_capture) begin
                    pending_d = 1'b0;
                    idx_d     = 4'd0;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                tx_data_d = w_byte;
                state_d   = START;
            end
            START: state_d = WAIT_HI;
            WAIT_HI: begin
                if (i_tx_busy) begin
                    state_d = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (!i_tx_busy) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = LOAD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Requests during a frame collapse into a single queued frame.
        if ((state_q != IDLE) && i_report) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            idx_q     <= 4'd0;
            pending_q <= 1'b0;
            tx_data_q <= 8'h00;
            msec_q    <= 7'd0;
            sec_q     <= 6'd0;
            min_q     <= 6'd0;
            hour_q    <= 5'd0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            tx_data_q <= tx_data_d;
            if (w_capture) begin
                msec_q <= msec;
                sec_q  <= sec;
                min_q  <= min;
                hour_q <= hour;
            end
        end
    end

    assign o_tx_data  = tx_data_q;
    assign o_tx_start = (state_q == START);
    assign o_busy     = (state_q != IDLE);

endmodule
`default_nettype wire
